instr_mem_loader: RTL

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/instr_mem_loader.sv | 120 ++++++++++++
 1 files changed

// File: rtl/instr_mem_loader.sv
// Streams 32-bit words from a valid/ready source into a byte-wide memory,
// writing each word as four little-endian byte writes at consecutive addresses.
module instr_mem_loader #(
  parameter int A_length = 12,
  parameter int D_length = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [A_length-1:0]   base_addr,
  input  logic [A_length-2:0]   word_count,
  input  logic                  in_valid,
  input  logic [31:0]           in_data,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [A_length-1:0]   wr_addr,
  output logic [D_length-1:0]   wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_WORD = 2'd1,
    WRITE     = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [A_length-1:0]   addr_q, addr_d;
  logic [A_length-2:0]   count_q, count_d;
  logic [31:0]           word_q, word_d;
  logic [1:0]            idx_q, idx_d;
  logic                  err_q, err_d;

  logic [A_length:0]     addr_adv;
  logic [A_length-2:0]   count_dec;
  logic [7:0]            byte_sel;

  assign addr_adv  = {1'b0, addr_q} + (A_length+1)'(4);
  assign count_dec = count_q - 1'b1;
  assign byte_sel  = word_q[8*idx_q +: 8];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    word_d  = word_q;
    idx_d   = idx_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = {base_addr[A_length-1:2], 2'b00};
          count_d = word_count;
          err_d   = 1'b0;
          state_d = (word_count == '0) ? DONE : WAIT_WORD;
        end
      end
      WAIT_WORD: begin
        if (in_valid) begin
          word_d  = in_data;
          idx_d   = 2'd0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          addr_d  = addr_adv[A_length-1:0];
          count_d = count_dec;
          // The next word's bytes land at a wrapped address only if one follows.
          if (addr_adv[A_length] && (count_dec != '0)) begin
            err_d = 1'b1;
          end
          state_d = (count_dec != '0) ? WAIT_WORD : DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      count_q <= '0;
      word_q  <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode from state so an asserted reset clears them without a clock.
  always_comb begin
    in_ready = (state_q == WAIT_WORD);
    wr_en    = (state_q == WRITE);
    busy     = (state_q != IDLE);
    done     = (state_q == DONE);
    err      = err_q;
    wr_addr  = '0;
    wr_data  = '0;
    if (state_q == WRITE) begin
      wr_addr = addr_q + A_length'(idx_q);
      wr_data = D_length'(byte_sel);
    end
  end

endmodule
